bcd_alu_seq: RTL and testbench

- Digit-serial sequencer for the calculator's 4-digit BCD arithmetic.
- Triggered by the control FSM's one-cycle ALU-enable pulse. Latches both saved operands, validates them, and for subtraction runs an MSD-first magnitude compare.
- Executes add/subtract one digit per cycle, LSD first, and returns the result with a done pulse.
- Sits between the calculator control FSM and the result/display registers.

---
 rtl/bcd_alu_seq.sv | 168 ++++++++++++++++
 tb/tb_bcd_alu_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alu_seq.sv
// Digit-serial 4-digit BCD add/subtract sequencer: CHECK, MSD-first CMP (subtract), LSD-first EXEC.
// Optional BCD_ALU_SEQ_SAT_EN: add overflow saturates the result to all 9s instead of wrapping.
module bcd_alu_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  clr,
    input  logic [1:0]            op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  neg,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    // Handshake: start is a one-cycle request honoured only in IDLE; done is a one-cycle
    // pulse during which result/neg/err are valid, and they hold until the next accept.
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_CMP   = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] op_a, op_b;
    logic [1:0]          op_q;
    logic [IW-1:0]       idx;
    logic                cy;
    logic                decided, lt;

    logic [3:0] da, db, digit;
    logic [4:0] sum, diff, sum_adj;
    logic       cout, bad, lt_next, decided_next;

    assign state_dbg = state;

    always_comb begin
        da = op_a[4*idx +: 4];
        db = op_b[4*idx +: 4];
        sum     = {1'b0, da} + {1'b0, db} + {4'b0, cy};
        sum_adj = sum - 5'd10;
        diff    = {1'b0, da} - {1'b0, db} - {4'b0, cy};
        digit = 4'd0;
        cout  = 1'b0;
        if (op_q == 2'b00) begin
            if (sum > 5'd9) begin
                digit = sum_adj[3:0];
                cout  = 1'b1;
            end else begin
                digit = sum[3:0];
            end
        end else begin
            // A negative difference wraps mod 16; adding 10 lands on the correct decimal digit.
            if (diff[4]) begin
                digit = diff[3:0] + 4'd10;
                cout  = 1'b1;
            end else begin
                digit = diff[3:0];
            end
        end
        decided_next = decided | (da != db);
        lt_next      = decided ? lt : (da < db);
        bad = op_q[1];
        for (int i = 0; i < DIGITS; i++) begin
            if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn || clr) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_q    <= 2'b00;
            idx     <= '0;
            cy      <= 1'b0;
            decided <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        op_q   <= op;
                        result <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cy      <= 1'b0;
                    decided <= 1'b0;
                    lt      <= 1'b0;
                    if (bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (op_q == 2'b00) begin
                        idx   <= '0;
                        state <= S_EXEC;
                    end else begin
                        idx   <= LAST;
                        state <= S_CMP;
                    end
                end
                S_CMP: begin
                    decided <= decided_next;
                    lt      <= lt_next;
                    if (idx == '0) begin
                        if (lt_next) begin
                            op_a <= op_b;
                            op_b <= op_a;
                        end
                        neg   <= lt_next;
                        state <= S_EXEC;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_EXEC: begin
                    result[4*idx +: 4] <= digit;
                    cy <= cout;
                    if (idx == LAST) begin
                        if (op_q == 2'b00 && cout) begin
                            err <= 1'b1;
`ifdef BCD_ALU_SEQ_SAT_EN
                            result <= {DIGITS{4'd9}};
`else
                            result[4*idx +: 4] <= digit;
`endif
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq: directed test-plan steps plus random ops against a decimal model.
module tb_bcd_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn, start, clr;
    logic [1:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, neg, err;
    logic [2:0]   state_dbg;

    int checks = 0;
    int fails  = 0;
    logic [W-1:0] exp_q[$];

    bcd_alu_seq #(.DIGITS(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .clr(clr), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .neg(neg), .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal-level reference: validity, sum/difference magnitudes and latency in edges.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [1:0] mop,
                         output logic [W-1:0] r, output logic n, output logic e, output int lat);
        logic ok = 1'b1;
        int x, y;
        for (int i = 0; i < 4; i++) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        if (mop[1]) ok = 1'b0;
        r = '0; n = 1'b0; e = 1'b0; lat = 1;
        if (!ok) begin
            e = 1'b1;
        end else begin
            x = bcd2int(ma);
            y = bcd2int(mb);
            if (mop == 2'b00) begin
                lat = 5;
                if (x + y > 9999) begin
                    e = 1'b1;
`ifdef BCD_ALU_SEQ_SAT_EN
                    r = 16'h9999;
`else
                    r = int2bcd((x + y) % 10000);
`endif
                end else begin
                    r = int2bcd(x + y);
                end
            end else begin
                lat = 9;
                if (x >= y) r = int2bcd(x - y);
                else begin
                    r = int2bcd(y - x);
                    n = 1'b1;
                end
            end
        end
    endtask

    // Runs one operation; inject>=0 pulses a second, ignored start that many cycles after E0.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [1:0] top, input int inject);
        logic [W-1:0] er, got_r;
        logic en, ee;
        int lat, n;
        logic got;
        model(ta, tb_v, top, er, en, ee, lat);
        exp_q.push_back(er);
        @(negedge clk);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        chk({tag, "_busy_e0"}, busy, 1);
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            start = (n == inject);
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
            else if (busy !== 1'b1) chk({tag, "_busy_run"}, busy, 1);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_latency"}, n, lat);
        got_r = exp_q.pop_front();
        chk({tag, "_result"}, result, got_r);
        chk({tag, "_neg"}, neg, en);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_busy_done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_hold"}, result, got_r);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        int           sel;
        resetn = 1'b1; start = 1'b0; clr = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_neg_err", {neg, err}, 0);
        chk("rst_state", state_dbg, 0);
        resetn = 1'b0;

        run_op("add", 16'h1234, 16'h5678, 2'b00, -1);
        // start in the DONE cycle is ignored: run_op ended one cycle after DONE, so redo it here
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_start_accept", state_dbg, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_done", done, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_ignored_state", state_dbg, 0);
        chk("b2b_ignored_busy", busy, 0);

        run_op("sub_neg", 16'h0012, 16'h0345, 2'b01, -1);
        run_op("sub_zero", 16'h4321, 16'h4321, 2'b01, -1);
        run_op("add_ovf", 16'h9999, 16'h0001, 2'b00, -1);
        run_op("bad_nib", 16'h12A4, 16'h0001, 2'b00, -1);
        run_op("bad_op", 16'h1111, 16'h2222, 2'b11, -1);
        run_op("busy_start", 16'h0500, 16'h0750, 2'b01, 2);

        // clr during the second CMP cycle
        @(negedge clk);
        a = 16'h5555; b = 16'h1111; op = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_state", state_dbg, 0);
        chk("clr_outs", {busy, done, neg, err}, 0);
        chk("clr_result", result, 0);
        sel = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) sel++;
        end
        chk("clr_no_done", sel, 0);

        // reset in the middle of EXEC
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        chk("midrst_outs", {busy, done, neg, err}, 0);
        chk("midrst_result", result, 0);
        chk("midrst_state", state_dbg, 0);
        run_op("after_rst", 16'h0808, 16'h0192, 2'b00, -1);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            sel = $urandom_range(0, 7);
            rop = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel == 6) ? 2'b10 : 2'b11;
            run_op("rand", ra, rb, rop, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
